// File: rtl/key_event_classifier.sv
// key_event_classifier: turns debounced key edges into short-press, long-press and auto-repeat pulses.
// Auto-repeat is built only when KEY_REPEAT_EN is defined; otherwise repeat_pulse is tied low.
module key_event_classifier #(
  parameter int FREQ      = 50,
  parameter int LONG_MS   = 1000,
  parameter int REPEAT_MS = 200,
  parameter int N         = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic key_level,
  input  logic key_press,
  input  logic key_release,
  output logic short_press,
  output logic long_press,
  output logic repeat_pulse,
  output logic key_held
);
  localparam logic [N-1:0] TICK_END = N'(FREQ * 1000 - 1);
  localparam logic [N-1:0] LONG_END = N'(LONG_MS - 1);
`ifdef KEY_REPEAT_EN
  localparam logic [N-1:0] REP_END = N'(REPEAT_MS - 1);
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, PRESS, HOLD} state_t;

  state_t       state_q, state_d;
  logic [N-1:0] cyc_q, cyc_d, ms_q, ms_d;
  logic         short_d, long_d, rep_d, adv;
  logic         tick, long_hit, rep_hit;

  assign tick     = cyc_q == TICK_END;
  assign long_hit = tick && ms_q == LONG_END;
`ifdef KEY_REPEAT_EN
  assign rep_hit  = tick && ms_q == REP_END;
`else
  assign rep_hit  = 1'b0;
`endif

  // Release beats level-based abort, which beats any threshold on the same edge.
  always_comb begin
    state_d = state_q;
    short_d = 1'b0;
    long_d  = 1'b0;
    rep_d   = 1'b0;
    adv     = 1'b0;
    case (state_q)
      IDLE: if (key_press) state_d = PRESS;
      PRESS:
        if (key_release) begin
          state_d = IDLE;
          short_d = 1'b1;
        end else if (key_level) state_d = IDLE;
        else if (long_hit) begin
          state_d = HOLD;
          long_d  = 1'b1;
        end else adv = 1'b1;
      HOLD:
        if (key_release || key_level) state_d = IDLE;
        else if (rep_hit) rep_d = 1'b1;
        else adv = REP_EN;
      default: state_d = IDLE;
    endcase
    cyc_d = adv ? (tick ? '0 : cyc_q + N'(1)) : '0;
    ms_d  = adv ? (tick ? ms_q + N'(1) : ms_q) : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cyc_q        <= '0;
      ms_q         <= '0;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      repeat_pulse <= 1'b0;
      key_held     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cyc_q        <= cyc_d;
      ms_q         <= ms_d;
      short_press  <= short_d;
      long_press   <= long_d;
      repeat_pulse <= rep_d;
      key_held     <= state_d != IDLE;
    end
  end
endmodule

// File: tb/tb_key_event_classifier.sv
// tb_key_event_classifier: random and directed key scenarios checked every cycle against an elapsed-time model.
module tb_key_event_classifier;
  localparam int T = 1000, L = 5, R = 2;
`ifdef KEY_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b0, key_level = 1'b1, key_press = 1'b0, key_release = 1'b0;
  logic short_press, long_press, repeat_pulse, key_held;
  int checks = 0, errors = 0;
  int edge_n = 0, n_short = 0, n_long = 0, n_rep = 0, short_at = -1, long_at = -1;
  int rep_at[$];
  bit m_act = 0, m_hold = 0, e_short = 0, e_long = 0, e_rep = 0, e_held = 0;
  int m_t = 0;

  key_event_classifier #(.FREQ(1), .LONG_MS(L), .REPEAT_MS(R), .N(32)) dut (
    .clk(clk), .rst(rst), .key_level(key_level), .key_press(key_press),
    .key_release(key_release), .short_press(short_press), .long_press(long_press),
    .repeat_pulse(repeat_pulse), .key_held(key_held)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n++;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at edge %0d", name, got, exp, edge_n);
    end
  endtask

  // Model: elapsed edges since entering the current press/hold phase decide the events.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_act = 0; m_hold = 0; m_t = 0;
      e_short = 0; e_long = 0; e_rep = 0; e_held = 0;
    end else begin
      e_short = 0; e_long = 0; e_rep = 0;
      if (!m_act) begin
        if (key_press) begin m_act = 1; m_hold = 0; m_t = 0; end
      end else begin
        m_t++;
        if (key_release) begin e_short = !m_hold; m_act = 0; end
        else if (key_level) m_act = 0;
        else if (!m_hold && m_t == L * T) begin e_long = 1; m_hold = 1; m_t = 0; end
        else if (m_hold && REP && m_t == R * T) begin e_rep = 1; m_t = 0; end
      end
      e_held = m_act;
    end
  end

  always @(negedge clk) if (rst) begin
    check("short_press", short_press, e_short);
    check("long_press", long_press, e_long);
    check("repeat_pulse", repeat_pulse, e_rep);
    check("key_held", key_held, e_held);
    check("pulse_onehot", int'(short_press) + int'(long_press) + int'(repeat_pulse) <= 1, 1);
    if (short_press) begin n_short++; short_at = edge_n; end
    if (long_press) begin n_long++; long_at = edge_n; end
    if (repeat_pulse) begin n_rep++; rep_at.push_back(edge_n); end
  end

  // Press, then end with the release/abort/reset sampled on edge p+n.
  task automatic press_for(input int n, input int endk, input bit spur, output int p);
    int s0, l0, r0;
    @(negedge clk); key_press = 1; key_level = 0;
    @(negedge clk); key_press = 0; p = edge_n;
    repeat (n - 1) begin
      @(negedge clk);
      key_press = spur && ($urandom_range(0, 199) == 0);
    end
    if (endk == 0) begin
      key_release = 1; key_level = 1;
      @(negedge clk); key_release = 0; key_press = 0;
    end else if (endk == 1) begin
      key_level = 1;
      @(negedge clk); key_press = 0;
    end else begin
      rst = 0; key_press = 0;
      #1;
      check("rst_async_held", key_held, 0);
      check("rst_async_pulses", {short_press, long_press, repeat_pulse}, 0);
      repeat (3) @(negedge clk);
      rst = 1;
      repeat (5) @(negedge clk);
      check("held_after_rst", key_held, 0);
      s0 = n_short; l0 = n_long; r0 = n_rep;
      key_release = 1; key_level = 1;
      @(negedge clk); key_release = 0;
      repeat (3) @(negedge clk);
      check("stray_release_pulses", (n_short - s0) + (n_long - l0) + (n_rep - r0), 0);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int p, s0, l0, r0, n, k;
    repeat (3) begin @(negedge clk); key_press = ~key_press; end
    check("rst_short", short_press, 0);
    check("rst_long", long_press, 0);
    check("rst_repeat", repeat_pulse, 0);
    check("rst_held", key_held, 0);
    key_press = 0; key_level = 0;
    @(negedge clk); rst = 1;
    repeat (10) @(negedge clk);
    check("no_press_level_low", key_held, 0);
    key_level = 1;
    repeat (3) @(negedge clk);

    s0 = n_short; l0 = n_long;
    press_for(2000, 0, 0, p);
    check("short_count", n_short - s0, 1);
    check("short_time", short_at - p, 2000);
    check("short_no_long", n_long - l0, 0);
    check("short_held_after", key_held, 0);

    s0 = n_short; l0 = n_long;
    press_for(6000, 0, 0, p);
    check("long_count", n_long - l0, 1);
    check("long_time", long_at - p, 5000);
    check("long_no_short", n_short - s0, 0);

    l0 = n_long; r0 = n_rep; rep_at.delete();
    press_for(9500, 0, 0, p);
    check("rep_long_count", n_long - l0, 1);
    check("rep_count", n_rep - r0, REP ? 2 : 0);
    foreach (rep_at[i]) check("rep_time", rep_at[i] - p, 7000 + 2000 * i);

    s0 = n_short; l0 = n_long;
    press_for(5000, 0, 0, p);
    check("coinc_short", n_short - s0, 1);
    check("coinc_short_time", short_at - p, 5000);
    check("coinc_no_long", n_long - l0, 0);

    s0 = n_short; l0 = n_long; r0 = n_rep;
    press_for(7000, 0, 0, p);
    check("coinc_rep_long", n_long - l0, 1);
    check("coinc_no_rep", n_rep - r0, 0);
    check("coinc_rep_no_short", n_short - s0, 0);

    l0 = n_long;
    press_for(6000, 2, 0, p);
    check("midrst_long", n_long - l0, 1);
    l0 = n_long;
    press_for(5200, 0, 0, p);
    check("after_rst_long_time", long_at - p, 5000);
    check("after_rst_long_count", n_long - l0, 1);

    s0 = n_short; l0 = n_long;
    press_for(300, 1, 0, p);
    check("lost_release_pulses", (n_short - s0) + (n_long - l0), 0);
    check("lost_release_held", key_held, 0);

    for (int i = 0; i < 5; i++) begin
      k = $urandom_range(0, 3);
      n = (k == 0) ? 4999 + $urandom_range(0, 2) : $urandom_range(1, 6000);
      repeat ($urandom_range(1, 20)) @(negedge clk);
      press_for(n, $urandom_range(0, 9) < 7 ? 0 : $urandom_range(1, 2), 1, p);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
